// File: rtl/zbus_strobe.sv
`default_nettype none
// ============================================================================
// Module   : zbus_strobe
// Purpose  : Conditions the ZX-bus read/write strobes for the on-board chips
//            (w5300, sl811). Z80 RD_N/WR_N and the chip-select qualifier are
//            resynchronised into fclk, then re-issued as registered strobes
//            with a bounded write pulse and an enforced recovery gap, so chip
//            timing is independent of the Z80 strobe width.
// Ports    : fclk    - 48 MHz system clock
//            rst_n   - asynchronous active-low reset
//            zrd_n   - Z80 RD_N (async)
//            zwr_n   - Z80 WR_N (async)
//            zsel    - access targets an on-board chip (async, active high)
//            brd_n   - buffered read strobe (registered)
//            bwr_n   - buffered write strobe (registered)
//            busy    - high whenever the sequencer is not idle
//            wr_done - one-cycle pulse in the cycle bwr_n returns high
//            collide - sticky: read and write requests seen together
// Revision : 1.0 - initial release
// ============================================================================
module zbus_strobe #(
    parameter int SYNC_STAGES = 2,  // 2..3
    parameter int WR_PULSE    = 6,  // 2..15
    parameter int RECOVERY    = 2   // 1..7
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic zrd_n,
    input  logic zwr_n,
    input  logic zsel,
    output logic brd_n,
    output logic bwr_n,
    output logic busy,
    output logic wr_done,
    output logic collide
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_ACT  = 3'd1;
    localparam logic [2:0] c_ST_WR_ACT  = 3'd2;
    localparam logic [2:0] c_ST_WR_WAIT = 3'd3;
    localparam logic [2:0] c_ST_RECOVER = 3'd4;

    localparam logic [3:0] c_WR_LOAD  = 4'(WR_PULSE - 1);
    localparam logic [3:0] c_REC_LOAD = 4'(RECOVERY - 1);

    // ------------------------------------------------------------------
    // Input synchronisers. Strobes idle high, select idles low, so a reset
    // chain never presents a spurious request.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_sel_sync;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_sync  <= '1;
            r_wr_sync  <= '1;
            r_sel_sync <= '0;
        end else begin
            r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], zrd_n};
            r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], zwr_n};
            r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], zsel};
        end
    end

    logic w_rd_req;
    logic w_wr_req;

    assign w_rd_req = ~r_rd_sync[SYNC_STAGES-1] & r_sel_sync[SYNC_STAGES-1];
    assign w_wr_req = ~r_wr_sync[SYNC_STAGES-1] & r_sel_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Write has priority when both requests are present.
                if (w_wr_req) begin
                    w_state_nxt = c_ST_WR_ACT;
                    w_cnt_nxt   = c_WR_LOAD;
                end else if (w_rd_req) begin
                    w_state_nxt = c_ST_RD_ACT;
                end
            end
            c_ST_RD_ACT: begin
                if (!w_rd_req) begin
                    w_state_nxt = c_ST_RECOVER;
                    w_cnt_nxt   = c_REC_LOAD;
                end
            end
            c_ST_WR_ACT: begin
                // A Z80 strobe ending early takes precedence over pulse expiry.
                if (!w_wr_req) begin
                    w_state_nxt = c_ST_RECOVER;
                    w_cnt_nxt   = c_REC_LOAD;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_WR_WAIT;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_ST_WR_WAIT: begin
                // Park until the Z80 releases WR_N: one chip write per cycle.
                if (!w_wr_req) begin
                    w_state_nxt = c_ST_RECOVER;
                    w_cnt_nxt   = c_REC_LOAD;
                end
            end
            c_ST_RECOVER: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so every strobe is glitch-free and has no input-to-output path.
    logic r_brd_n;
    logic r_bwr_n;
    logic r_busy;
    logic r_wr_done;
    logic r_collide;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 4'd0;
            r_brd_n   <= 1'b1;
            r_bwr_n   <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_done <= 1'b0;
            r_collide <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_brd_n   <= (w_state_nxt != c_ST_RD_ACT);
            r_bwr_n   <= (w_state_nxt != c_ST_WR_ACT);
            r_busy    <= (w_state_nxt != c_ST_IDLE);
            r_wr_done <= w_done_nxt;
            r_collide <= r_collide | (w_rd_req & w_wr_req);
        end
    end

    assign brd_n   = r_brd_n;
    assign bwr_n   = r_bwr_n;
    assign busy    = r_busy;
    assign wr_done = r_wr_done;
    assign collide = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_zbus_strobe.sv
`default_nettype none
// ============================================================================
// Module   : tb_zbus_strobe
// Purpose  : Self-checking bench for zbus_strobe. Inputs change on the falling
//            edge of fclk, which makes the synchroniser delay deterministic;
//            a reference model built from the access rules (request history
//            queue, pulse length and gap counters) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zbus_strobe;

    localparam int SYNC_STAGES = 2;
    localparam int WR_PULSE    = 6;
    localparam int RECOVERY    = 2;

    logic fclk  = 1'b0;
    logic rst_n = 1'b0;
    logic zrd_n = 1'b1;
    logic zwr_n = 1'b1;
    logic zsel  = 1'b0;
    logic brd_n;
    logic bwr_n;
    logic busy;
    logic wr_done;
    logic collide;

    int tests_run    = 0;
    int tests_failed = 0;

    zbus_strobe #(
        .SYNC_STAGES(SYNC_STAGES),
        .WR_PULSE   (WR_PULSE),
        .RECOVERY   (RECOVERY)
    ) dut (
        .fclk   (fclk),
        .rst_n  (rst_n),
        .zrd_n  (zrd_n),
        .zwr_n  (zwr_n),
        .zsel   (zsel),
        .brd_n  (brd_n),
        .bwr_n  (bwr_n),
        .busy   (busy),
        .wr_done(wr_done),
        .collide(collide)
    );

    always #5 fclk = ~fclk;

    logic [4:0] w_obs;
    assign w_obs = {brd_n, bwr_n, busy, wr_done, collide};

    // ------------------------------------------------------------------
    // Reference model
    //   hist   : input samples; the one popped at an edge is what the DUT
    //            sees as a synchronised request at that edge.
    //   m_rd   : a read strobe is being passed through
    //   m_wlen : cycles the write strobe has been low so far (0 = none)
    //   m_whold: write finished, waiting for the Z80 to release WR_N
    //   m_gap  : remaining recovery cycles
    // ------------------------------------------------------------------
    typedef struct packed {
        logic rd_n;
        logic wr_n;
        logic sel;
    } zin_t;

    zin_t hist[$];
    bit   m_rd, m_whold, m_coll, m_done;
    int   m_wlen, m_gap;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(3'b110);
        m_rd = 0; m_whold = 0; m_coll = 0; m_done = 0;
        m_wlen = 0; m_gap = 0;
    endfunction

    function automatic void model_step();
        zin_t cur;
        zin_t old;
        bit   rq, wq;
        cur = {zrd_n, zwr_n, zsel};
        hist.push_back(cur);
        old = hist.pop_front();
        rq = !old.rd_n && old.sel;
        wq = !old.wr_n && old.sel;
        if (rq && wq) m_coll = 1;
        m_done = 0;
        if (m_gap > 0) begin
            m_gap--;
        end else if (m_rd) begin
            if (!rq) begin m_rd = 0; m_gap = RECOVERY; end
        end else if (m_wlen > 0) begin
            if (!wq) begin
                m_wlen = 0; m_done = 1; m_gap = RECOVERY;
            end else if (m_wlen == WR_PULSE) begin
                m_wlen = 0; m_done = 1; m_whold = 1;
            end else begin
                m_wlen++;
            end
        end else if (m_whold) begin
            if (!wq) begin m_whold = 0; m_gap = RECOVERY; end
        end else if (wq) begin
            m_wlen = 1;
        end else if (rq) begin
            m_rd = 1;
        end
    endfunction

    function automatic logic [4:0] model_out();
        logic b;
        b = (m_gap > 0) || m_rd || (m_wlen > 0) || m_whold;
        return {!m_rd, !(m_wlen > 0), b, m_done, m_coll};
    endfunction

    // One clock: model advances with the DUT's edge, return at the falling
    // edge where outputs are sampled and new inputs are driven.
    task automatic tick();
        @(posedge fclk);
        if (rst_n) model_step();
        @(negedge fclk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [4:0] exp;
        rst_n = 1'b0; zrd_n = 1'b1; zwr_n = 1'b0; zsel = 1'b1;
        model_reset();
        repeat (3) tick();
        tests_run++;
        if (w_obs !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reset_hold: {brd,bwr,busy,done,coll} got %b need 11000", w_obs);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            tests_run++;
            if (bwr_n !== ((e >= 3) ? 1'b0 : 1'b1)) begin
                tests_failed++;
                $display("FAIL reset_release edge %0d: bwr_n got %b need %b", e, bwr_n, (e >= 3) ? 1'b0 : 1'b1);
            end
            exp = model_out();
            tests_run++;
            if (w_obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_release_model edge %0d: got %b need %b", e, w_obs, exp);
            end
        end
        // Reset in the middle of the write pulse: outputs must clear at once.
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (w_obs !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reset_mid_access: got %b need 11000", w_obs);
        end
        model_reset();
        @(negedge fclk);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            if (e == 5) begin zwr_n = 1'b1; zsel = 1'b0; end
            tick();
            exp = model_out();
            tests_run++;
            if (w_obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_restart cyc %0d: got %b need %b", e, w_obs, exp);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Drives a single write of low_len cycles and checks the pulse shape.
    task automatic run_write(input string name, input int low_len,
                             input int need_low, input int need_busy);
        logic [4:0] exp;
        logic       prev_bwr;
        int         lows, falls, dones, done_on_rise, busys;
        lows = 0; falls = 0; dones = 0; done_on_rise = 0; busys = 0;
        prev_bwr = bwr_n;
        zsel = 1'b1; zrd_n = 1'b1; zwr_n = 1'b0;
        for (int c = 0; c < low_len + 14; c++) begin
            if (c == low_len) zwr_n = 1'b1;
            tick();
            exp = model_out();
            tests_run++;
            if (w_obs !== exp) begin
                tests_failed++;
                $display("FAIL %s_model cyc %0d: got %b need %b", name, c, w_obs, exp);
            end
            if (!bwr_n) lows++;
            if (prev_bwr && !bwr_n) falls++;
            if (wr_done) dones++;
            if (wr_done && !prev_bwr && bwr_n) done_on_rise++;
            if (busy) busys++;
            prev_bwr = bwr_n;
        end
        tests_run++;
        if (lows !== need_low) begin
            tests_failed++;
            $display("FAIL %s_width: bwr_n low %0d cycles, need %0d", name, lows, need_low);
        end
        tests_run++;
        if (falls !== 1) begin
            tests_failed++;
            $display("FAIL %s_pulses: %0d bwr_n pulses, need 1", name, falls);
        end
        tests_run++;
        if (dones !== 1 || done_on_rise !== 1) begin
            tests_failed++;
            $display("FAIL %s_wr_done: %0d pulses (%0d on rise), need 1 (1)", name, dones, done_on_rise);
        end
        tests_run++;
        if (busys !== need_busy) begin
            tests_failed++;
            $display("FAIL %s_busy: busy %0d cycles, need %0d", name, busys, need_busy);
        end
    endtask

    task automatic test_long_write();
        // Busy: sync delay shifts the whole access; it spans the input low
        // time plus the two recovery cycles.
        run_write("long_write", 20, WR_PULSE, 20 + RECOVERY);
    endtask

    task automatic test_short_write();
        run_write("short_write", 3, 3, 3 + RECOVERY);
    endtask

    // ------------------------------------------------------------------
    task automatic test_read();
        logic [4:0] exp;
        int lows, first;
        for (int pass = 0; pass < 2; pass++) begin
            lows = 0; first = -1;
            zsel = (pass == 0); zwr_n = 1'b1; zrd_n = 1'b0;
            for (int c = 1; c <= 24; c++) begin
                if (c == 11) zrd_n = 1'b1;
                tick();
                exp = model_out();
                tests_run++;
                if (w_obs !== exp) begin
                    tests_failed++;
                    $display("FAIL read%0d_model cyc %0d: got %b need %b", pass, c, w_obs, exp);
                end
                if (!brd_n) begin
                    lows++;
                    if (first < 0) first = c;
                end
            end
            tests_run++;
            if (lows !== ((pass == 0) ? 10 : 0)) begin
                tests_failed++;
                $display("FAIL read%0d_width: brd_n low %0d cycles, need %0d", pass, lows, (pass == 0) ? 10 : 0);
            end
            if (pass == 0) begin
                tests_run++;
                if (first !== SYNC_STAGES + 1) begin
                    tests_failed++;
                    $display("FAIL read_latency: brd_n fell at edge %0d, need %0d", first, SYNC_STAGES + 1);
                end
            end
        end
        zsel = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [4:0] exp;
        logic       prev_brd, prev_bwr;
        int         rise, fall;
        rise = -1; fall = -1;
        prev_brd = brd_n; prev_bwr = bwr_n;
        zsel = 1'b1; zwr_n = 1'b1; zrd_n = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 7)  zrd_n = 1'b1;
            if (c == 8)  zwr_n = 1'b0;
            if (c == 16) zwr_n = 1'b1;
            tick();
            exp = model_out();
            tests_run++;
            if (w_obs !== exp) begin
                tests_failed++;
                $display("FAIL b2b_model cyc %0d: got %b need %b", c, w_obs, exp);
            end
            if (!prev_brd && brd_n && rise < 0) rise = c;
            if (prev_bwr && !bwr_n && fall < 0) fall = c;
            prev_brd = brd_n; prev_bwr = bwr_n;
        end
        tests_run++;
        if (rise < 0 || fall < 0 || (fall - rise) < RECOVERY + 1) begin
            tests_failed++;
            $display("FAIL b2b_gap: brd_n rise %0d, bwr_n fall %0d, need gap >= %0d", rise, fall, RECOVERY + 1);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_collision();
        logic [4:0] exp;
        int rd_lows, wr_lows;
        rd_lows = 0; wr_lows = 0;
        zsel = 1'b1; zrd_n = 1'b0; zwr_n = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) begin zrd_n = 1'b1; zwr_n = 1'b1; end
            tick();
            exp = model_out();
            tests_run++;
            if (w_obs !== exp) begin
                tests_failed++;
                $display("FAIL collision_model cyc %0d: got %b need %b", c, w_obs, exp);
            end
            if (!brd_n) rd_lows++;
            if (!bwr_n) wr_lows++;
        end
        tests_run++;
        if (rd_lows !== 0 || wr_lows !== WR_PULSE) begin
            tests_failed++;
            $display("FAIL collision_strobes: brd_n low %0d bwr_n low %0d, need 0 and %0d", rd_lows, wr_lows, WR_PULSE);
        end
        tests_run++;
        if (collide !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_sticky: collide got %b need 1", collide);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (collide !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_clear: collide got %b need 0", collide);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic [4:0] exp;
        for (int c = 0; c < 4000; c++) begin
            if (c % 800 == 799) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            if ($urandom_range(7) == 0)  zrd_n = ~zrd_n;
            if ($urandom_range(7) == 0)  zwr_n = ~zwr_n;
            if ($urandom_range(15) == 0) zsel  = ~zsel;
            tick();
            exp = model_out();
            tests_run++;
            if (w_obs !== exp) begin
                tests_failed++;
                $display("FAIL random cyc %0d: in rd=%b wr=%b sel=%b got %b need %b",
                         c, zrd_n, zwr_n, zsel, w_obs, exp);
            end
        end
        rst_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1;
        repeat (12) tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_long_write();
        test_short_write();
        test_read();
        test_back_to_back();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
